// File: rtl/trace_scorer.sv
// trace_scorer: running score, session high score and frozen final score
// for the trace game. Optional macro SNITCH_DOUBLE_EN doubles hit points.
//
// Ports:
//   clock, resetn       clock, async active-low reset
//   curr_screen[4:0]    screen index (1 title, even trace, odd>1 message)
//   snitch_powerup      snitch window level
//   end_of_game         game finished level
//   play_again          restart request level
//   trace_hit/miss      one-cycle trace pulses
//   score[15:0]         running score
//   high_score[15:0]    best final score since reset
//   score_valid         final score frozen for display
//   perfect_flag        one-cycle pulse on perfect bonus
module trace_scorer #(
    parameter int HIT_POINTS    = 10,
    parameter int MISS_PENALTY  = 5,
    parameter int PERFECT_BONUS = 100,
    parameter int MIN_HITS      = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [4:0]  curr_screen,
    input  logic        snitch_powerup,
    input  logic        end_of_game,
    input  logic        play_again,
    input  logic        trace_hit,
    input  logic        trace_miss,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        score_valid,
    output logic        perfect_flag
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PLAY   = 2'd1;
    localparam logic [1:0] TALLY  = 2'd2;
    localparam logic [1:0] FROZEN = 2'd3;

    localparam logic [15:0] MISS_PTS  = 16'(MISS_PENALTY);
    localparam logic [15:0] BONUS_PTS = 16'(PERFECT_BONUS);
    localparam logic [7:0]  MIN_CNT   = 8'(MIN_HITS);

    logic [1:0]  state, state_nxt;
    logic [4:0]  prev_screen;
    logic        prev_eog, prev_play;
    logic [7:0]  hit_cnt, miss_cnt;
    logic [7:0]  hit_cnt_nxt, miss_cnt_nxt;
    logic [15:0] score_nxt, high_nxt;
    logic        valid_nxt, perfect_nxt;
    logic [15:0] hit_pts;

    logic screen_chg, on_trace, was_trace;
    logic eog_rise, play_rise, hit_ev, miss_ev;

`ifdef SNITCH_DOUBLE_EN
    assign hit_pts = snitch_powerup ? 16'(2 * HIT_POINTS)
                                    : 16'(HIT_POINTS);
`else
    logic unused_snitch;
    assign unused_snitch = snitch_powerup;
    assign hit_pts = 16'(HIT_POINTS);
`endif

    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic logic [15:0] max16(input logic [15:0] a,
                                          input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

    assign screen_chg = (curr_screen != prev_screen);
    assign on_trace   = ~curr_screen[0];
    assign was_trace  = ~prev_screen[0];
    assign eog_rise   = end_of_game & ~prev_eog;
    assign play_rise  = play_again & ~prev_play;
    assign hit_ev     = trace_hit & on_trace;
    assign miss_ev    = trace_miss & on_trace;

    always_comb begin
        state_nxt    = state;
        score_nxt    = score;
        hit_cnt_nxt  = hit_cnt;
        miss_cnt_nxt = miss_cnt;
        high_nxt     = high_score;
        valid_nxt    = score_valid;
        perfect_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (curr_screen != 5'd1) begin
                    state_nxt    = PLAY;
                    score_nxt    = '0;
                    hit_cnt_nxt  = '0;
                    miss_cnt_nxt = '0;
                end
            end
            PLAY: begin
                // A simultaneous hit and miss counts as a hit only.
                if (hit_ev) begin
                    score_nxt   = sat_add(score, hit_pts);
                    hit_cnt_nxt = sat_inc(hit_cnt);
                end else if (miss_ev) begin
                    score_nxt    = (score > MISS_PTS) ? score - MISS_PTS : '0;
                    miss_cnt_nxt = sat_inc(miss_cnt);
                end
                // Leaving a trace screen keeps the counters for TALLY,
                // which clears them itself afterwards.
                if (screen_chg && was_trace) begin
                    state_nxt = TALLY;
                end else begin
                    if (screen_chg && on_trace) begin
                        hit_cnt_nxt  = '0;
                        miss_cnt_nxt = '0;
                    end
                    if (eog_rise) begin
                        state_nxt = FROZEN;
                        valid_nxt = 1'b1;
                        high_nxt  = max16(high_score, score_nxt);
                    end
                end
            end
            TALLY: begin
                if (miss_cnt == 8'd0 && hit_cnt >= MIN_CNT) begin
                    score_nxt   = sat_add(score, BONUS_PTS);
                    perfect_nxt = 1'b1;
                end
                hit_cnt_nxt  = '0;
                miss_cnt_nxt = '0;
                if (end_of_game) begin
                    state_nxt = FROZEN;
                    valid_nxt = 1'b1;
                    high_nxt  = max16(high_score, score_nxt);
                end else begin
                    state_nxt = PLAY;
                end
            end
            FROZEN: begin
                if (play_rise) begin
                    state_nxt = IDLE;
                    score_nxt = '0;
                    valid_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            prev_screen  <= 5'd1;
            prev_eog     <= 1'b0;
            prev_play    <= 1'b0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            score        <= '0;
            high_score   <= '0;
            score_valid  <= 1'b0;
            perfect_flag <= 1'b0;
        end else begin
            state        <= state_nxt;
            prev_screen  <= curr_screen;
            prev_eog     <= end_of_game;
            prev_play    <= play_again;
            hit_cnt      <= hit_cnt_nxt;
            miss_cnt     <= miss_cnt_nxt;
            score        <= score_nxt;
            high_score   <= high_nxt;
            score_valid  <= valid_nxt;
            perfect_flag <= perfect_nxt;
        end
    end

endmodule

// File: tb/tb_trace_scorer.sv
// tb_trace_scorer: directed vectors with hand-computed scores.
// Works with SNITCH_DOUBLE_EN defined or undefined.
module tb_trace_scorer;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  curr_screen;
    logic        snitch_powerup;
    logic        end_of_game;
    logic        play_again;
    logic        trace_hit;
    logic        trace_miss;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        score_valid;
    logic        perfect_flag;

`ifdef SNITCH_DOUBLE_EN
    localparam logic [15:0] S = 16'd215;
`else
    localparam logic [15:0] S = 16'd195;
`endif

    int checks = 0;
    int errors = 0;

    trace_scorer dut (
        .clock          (clock),
        .resetn         (resetn),
        .curr_screen    (curr_screen),
        .snitch_powerup (snitch_powerup),
        .end_of_game    (end_of_game),
        .play_again     (play_again),
        .trace_hit      (trace_hit),
        .trace_miss     (trace_miss),
        .score          (score),
        .high_score     (high_score),
        .score_valid    (score_valid),
        .perfect_flag   (perfect_flag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic h, input logic m);
        trace_hit  = h;
        trace_miss = m;
        @(posedge clock);
        #1;
        trace_hit  = 1'b0;
        trace_miss = 1'b0;
    endtask

    initial begin
        resetn         = 1'b0;
        curr_screen    = 5'd1;
        snitch_powerup = 1'b0;
        end_of_game    = 1'b0;
        play_again     = 1'b0;
        trace_hit      = 1'b0;
        trace_miss     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_score", score, 0);
        chk("rst_high", high_score, 0);
        chk("rst_valid", score_valid, 0);
        chk("rst_perfect", perfect_flag, 0);
        resetn = 1'b1;
        cyc(0, 0);

        // Game 1
        curr_screen = 5'd2;
        cyc(1, 0);
        chk("idle_hit_ignored", score, 0);
        repeat (3) cyc(1, 0);
        chk("three_hits", score, 30);
        cyc(0, 1);
        chk("one_miss", score, 25);
        curr_screen = 5'd3;
        cyc(0, 0);
        chk("tally_perf_lo", perfect_flag, 0);
        cyc(0, 0);
        chk("no_bonus", score, 25);
        chk("no_perfect", perfect_flag, 0);

        curr_screen = 5'd4;
        cyc(0, 0);
        repeat (4) cyc(1, 0);
        chk("four_hits", score, 65);
        curr_screen = 5'd5;
        cyc(0, 0);
        chk("bonus_lat1", score, 65);
        cyc(0, 0);
        chk("bonus", score, 165);
        chk("perfect_pulse", perfect_flag, 1);
        cyc(0, 0);
        chk("perfect_once", perfect_flag, 0);
        cyc(1, 1);
        chk("odd_ignored", score, 165);

        curr_screen = 5'd6;
        cyc(0, 0);
        cyc(1, 1);
        chk("hit_and_miss", score, 175);
        snitch_powerup = 1'b1;
        cyc(1, 0);
        cyc(1, 0);
        snitch_powerup = 1'b0;
        chk("snitch", score, S);

        // end of game on a trace-screen exit goes through TALLY
        curr_screen = 5'd7;
        end_of_game = 1'b1;
        cyc(0, 0);
        chk("eog_tally_valid", score_valid, 0);
        cyc(0, 0);
        chk("eog_valid", score_valid, 1);
        chk("g1_high", high_score, S);
        chk("g1_score", score, S);
        cyc(1, 0);
        chk("frozen_hold", score, S);

        end_of_game = 1'b0;
        play_again  = 1'b1;
        curr_screen = 5'd1;
        cyc(0, 0);
        chk("again_score", score, 0);
        chk("again_valid", score_valid, 0);
        chk("again_high", high_score, S);

        // Game 2 ends lower
        play_again  = 1'b0;
        curr_screen = 5'd2;
        cyc(0, 0);
        repeat (6) cyc(1, 0);
        chk("g2_hits", score, 60);
        end_of_game = 1'b1;
        cyc(0, 0);
        chk("g2_valid", score_valid, 1);
        chk("g2_score", score, 60);
        chk("g2_high", high_score, S);

        end_of_game = 1'b0;
        play_again  = 1'b1;
        curr_screen = 5'd1;
        cyc(0, 0);
        chk("g2_again_valid", score_valid, 0);

        // Game 3: floor and saturation
        play_again  = 1'b0;
        curr_screen = 5'd2;
        cyc(0, 0);
        cyc(1, 0);
        cyc(0, 1);
        cyc(0, 1);
        chk("floor_zero", score, 0);
        cyc(0, 1);
        chk("floor_hold", score, 0);
        curr_screen = 5'd3;
        cyc(0, 0);
        cyc(0, 0);
        chk("miss_no_perf", perfect_flag, 0);
        curr_screen = 5'd4;
        cyc(0, 0);
        repeat (6553) cyc(1, 0);
        chk("near_max", score, 65530);
        cyc(1, 0);
        chk("sat_hit", score, 16'hFFFF);
        cyc(1, 0);
        chk("sat_hold", score, 16'hFFFF);
        curr_screen = 5'd5;
        cyc(0, 0);
        cyc(0, 0);
        chk("sat_perf", perfect_flag, 1);
        chk("sat_bonus", score, 16'hFFFF);
        curr_screen = 5'd6;
        cyc(0, 0);
        cyc(0, 1);
        chk("sat_miss", score, 16'hFFFA);
        end_of_game = 1'b1;
        cyc(0, 0);
        chk("g3_valid", score_valid, 1);
        chk("g3_high", high_score, 16'hFFFA);

        // async reset while frozen
        #3;
        resetn = 1'b0;
        #1;
        chk("mid_rst_score", score, 0);
        chk("mid_rst_high", high_score, 0);
        chk("mid_rst_valid", score_valid, 0);
        chk("mid_rst_perf", perfect_flag, 0);
        resetn      = 1'b1;
        end_of_game = 1'b0;
        curr_screen = 5'd2;
        cyc(1, 0);
        chk("post_rst_idle", score, 0);
        cyc(1, 0);
        chk("post_rst_play", score, 10);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_scorer.md
# trace_scorer

Score-keeping stage directly downstream of the screen sequencer. It consumes the current screen number, the snitch power-up window, end-of-game and play-again. From these plus per-pixel trace hit/miss pulses it produces the running score, the session high score and a frozen final score for the scoreboard display. It owns all scoring arithmetic, so the display path only reads registers.

## Interface
- HIT_POINTS, 10, points per trace hit (doubled during snitch window when enabled)
- MISS_PENALTY, 5, points removed per trace miss
- PERFECT_BONUS, 100, bonus for a trace screen with zero misses and at least MIN_HITS hits
- MIN_HITS, 4, minimum hits for the perfect bonus
- clock  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- curr_screen  input  5  screen index from sequencer; 1 = title, even = trace screen, odd >1 = message screen
- snitch_powerup  input  1  level; snitch window active
- end_of_game  input  1  level; game finished
- play_again  input  1  level; restart request
- trace_hit  input  1  one-cycle pulse; cursor on trace pixel
- trace_miss  input  1  one-cycle pulse; cursor off trace
- score  output  16  running score
- high_score  output  16  best final score since reset
- score_valid  output  1  high while final score is frozen for display
- perfect_flag  output  1  one-cycle pulse when a perfect bonus is awarded

## Operation
- States: IDLE, PLAY, TALLY, FROZEN. Reset -> IDLE.
- Edge detection uses registered copies: prev_screen (reset 1), prev_eog, prev_play (reset 0).
- IDLE: hit/miss ignored. curr_screen != 1 -> PLAY, with score, hit_cnt and miss_cnt cleared.
- PLAY:
  - trace_hit on an even screen: score += HIT_POINTS; hit_cnt++ (8-bit, saturating at 255).
  - trace_miss on an even screen: score -= MISS_PENALTY, floored at 0; miss_cnt++ (saturating).
  - Hit and miss in the same cycle: treated as a hit only.
  - Pulses on odd screens are ignored.
  - Screen change where prev_screen is even -> TALLY.
  - Screen change to an even screen clears hit_cnt and miss_cnt.
- TALLY: one cycle.
  - If miss_cnt==0 and hit_cnt>=MIN_HITS: score += PERFECT_BONUS and perfect_flag pulses.
  - Counters clear. Then -> PLAY, or -> FROZEN if end_of_game is high.
- end_of_game rising edge in PLAY -> FROZEN, or via TALLY first if the same cycle is a trace-screen exit.
  - On entry to FROZEN: high_score <= max(high_score, score).
  - score_valid = 1; score holds.
- FROZEN: play_again rising edge -> IDLE; score cleared, score_valid = 0, high_score kept.
- Arithmetic: all additions saturate at 16'hFFFF; subtraction floors at 0. No wrap-around ever.

## Timing
- Outputs are registered. Reset values: score=0, high_score=0, score_valid=0, perfect_flag=0.
- Hit/miss to score update: 1 cycle.
- Screen change to bonus visible on score: 2 cycles (edge detect, then TALLY).
- end_of_game rise to score_valid high: 1 cycle, or 2 cycles if passing through TALLY.
- play_again rise to score=0 and score_valid=0: 1 cycle.
- Reset asserted mid-game: everything returns to reset values immediately, including high_score.

## Configuration
- SNITCH_DOUBLE_EN:
  - Defined: a hit while snitch_powerup=1 adds 2*HIT_POINTS.
  - Undefined: snitch_powerup is ignored and every hit adds HIT_POINTS.

## Test plan
- Reset, curr_screen 1->2, 3 hits, 1 miss -> score 25, no perfect_flag after the move to screen 3.
- Screen 2 with 4 hits, 0 misses, then curr_screen 3 -> score 40 then 140 two cycles after the change; perfect_flag pulses once.
- SNITCH_DOUBLE_EN defined: snitch_powerup=1, 2 hits -> score 40. Undefined -> score 20.
- Score 3, one miss -> 0. Preload near max, hit -> 16'hFFFF, no wrap.
- Game 1 ends at 140, game 2 ends at 60 -> high_score 140 both times; score_valid high in FROZEN and cleared one cycle after the play_again rise.
- resetn low while score_valid=1 -> all outputs 0, state IDLE; simultaneous hit+miss in PLAY -> +10 only.
